// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch widths, reset vector, PC step and FSM codes.
// Build option FC_MISALIGN_CHK_EN enables the FAULT state in fetch_ctrl.
package fetch_ctrl_pkg;

    localparam int InstrAddrBus = 32;
    localparam int InstrBus     = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: ROM port, redirect input and IF_ID valid/ready bundle.
// master = fetch_ctrl, slave = ROM / IF_ID / branch unit side.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = InstrAddrBus,
    parameter int INSTR_W = InstrBus
);

    logic [ADDR_W-1:0]  pc_addr_o_FC;
    logic               chip_enable_o_FC;
    logic [INSTR_W-1:0] instr_i_FC;
    logic               redirect_i_FC;
    logic [ADDR_W-1:0]  redirect_pc_i_FC;
    logic [INSTR_W-1:0] instr_o_FC;
    logic [ADDR_W-1:0]  pc_o_FC;
    logic               valid_o_FC;
    logic               ready_i_FC;
    logic               misalign_o_FC;

    modport master (
        output pc_addr_o_FC,
        output chip_enable_o_FC,
        input  instr_i_FC,
        input  redirect_i_FC,
        input  redirect_pc_i_FC,
        output instr_o_FC,
        output pc_o_FC,
        output valid_o_FC,
        input  ready_i_FC,
        output misalign_o_FC
    );

    modport slave (
        input  pc_addr_o_FC,
        input  chip_enable_o_FC,
        output instr_i_FC,
        output redirect_i_FC,
        output redirect_pc_i_FC,
        input  instr_o_FC,
        input  pc_o_FC,
        input  valid_o_FC,
        output ready_i_FC,
        input  misalign_o_FC
    );

endinterface

// File: rtl/fc_fifo.sv
// fc_fifo: small {pc, instr} queue with push, pop, flush and count.
// Flush wins over push/pop; DEPTH must be a power of two.
module fc_fifo #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o
);

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                pc_mem_d[wr_ptr_q]    = push_pc_i;
                instr_mem_d[wr_ptr_q] = push_instr_i;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner, ROM strobe sequencer and IF_ID queue front.
// Define FC_MISALIGN_CHK_EN to trap misaligned redirects in a FAULT state.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = InstrAddrBus,
    parameter int          INSTR_W  = InstrBus,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0],
    parameter int          DEPTH    = 2
) (
    input  logic          clk_i_FC,
    input  logic          reset_i_FC,
    fetch_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    fc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic               inflight_q, inflight_d;

    logic               redir;
    logic [ADDR_W-1:0]  tgt;
    logic               issue;
    logic               flush;
    logic               push;
    logic               pop;
    logic               valid;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occ;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;

`ifdef FC_MISALIGN_CHK_EN
    logic               misalign_q, misalign_d;
    logic               mis_tgt;
    assign mis_tgt = (bus.redirect_pc_i_FC[1:0] != 2'b00);
    assign tgt     = bus.redirect_pc_i_FC;
`else
    assign tgt     = bus.redirect_pc_i_FC & ~ADDR_W'(32'd3);
`endif

    assign redir = bus.redirect_i_FC;
    assign valid = (count != '0) && !redir;
    assign pop   = valid && bus.ready_i_FC;
    // occupancy after this cycle, counting the read still in flight
    assign occ   = {1'b0, count} + (CNT_W + 1)'(inflight_q)
                 - (CNT_W + 1)'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue      = 1'b0;
        flush      = 1'b0;
`ifdef FC_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redir) begin
                    flush = 1'b1;
`ifdef FC_MISALIGN_CHK_EN
                    if (mis_tgt) begin
                        state_d    = ST_FAULT;
                        misalign_d = 1'b1;
                    end else begin
                        fetch_pc_d = tgt;
                    end
`else
                    fetch_pc_d = tgt;
`endif
                end else if (occ < DEPTH_C) begin
                    issue      = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INC[ADDR_W-1:0];
                end
            end
`ifdef FC_MISALIGN_CHK_EN
            ST_FAULT: begin
                flush = 1'b1;
                if (redir && !mis_tgt) begin
                    state_d    = ST_RUN;
                    fetch_pc_d = tgt;
                    misalign_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // a read returning during a flush is the dropped one
    assign push       = inflight_q && !flush;
    assign inflight_d = issue;
    assign ipc_d      = fetch_pc_q;

    always_ff @(posedge clk_i_FC) begin
        if (!reset_i_FC) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
`ifdef FC_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
`ifdef FC_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    fc_fifo #(
        .PC_W    (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i_FC),
        .rst_ni       (reset_i_FC),
        .push_i       (push),
        .push_pc_i    (ipc_q),
        .push_instr_i (bus.instr_i_FC),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (count),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    assign bus.pc_addr_o_FC     = fetch_pc_q;
    assign bus.chip_enable_o_FC = issue;
    assign bus.valid_o_FC       = valid;
    assign bus.pc_o_FC          = head_pc;
    assign bus.instr_o_FC       = head_instr;
`ifdef FC_MISALIGN_CHK_EN
    assign bus.misalign_o_FC    = misalign_q;
`else
    assign bus.misalign_o_FC    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: cycle tables for the timing corners plus a random run
// checked against a fetch-stream model of the sequencer.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    fetch_ctrl #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i_FC   (clk),
        .reset_i_FC (rst_n),
        .bus        (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0F0F;
    endfunction

    // ROM: data one cycle after the strobe, junk otherwise
    always @(posedge clk)
        bus.instr_i_FC <= bus.chip_enable_o_FC ? rom_f(bus.pc_addr_o_FC)
                                               : 32'hBAD0_0BAD;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        bus.ready_i_FC = 1'b0;
        bus.redirect_i_FC = 1'b0;
        bus.redirect_pc_i_FC = '0;
        repeat (3) @(posedge clk);
        #1;
        if (check) begin
            chk("reset ce", bus.chip_enable_o_FC, 0);
            chk("reset addr", bus.pc_addr_o_FC, 32'h0);
            chk("reset valid", bus.valid_o_FC, 0);
            chk("reset instr_o", bus.instr_o_FC, 32'h0);
            chk("reset pc_o", bus.pc_o_FC, 32'h0);
            chk("reset misalign", bus.misalign_o_FC, 0);
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        ce;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rdy, input logic rdr, input logic [31:0] rpc,
                       input logic ce, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc,
                       input logic mis);
        vec_t v;
        v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.ce = ce; v.addr = addr; v.vld = vld; v.pc = pc; v.mis = mis;
        tv.push_back(v);
    endtask

    // cycle 0 of each table is the first cycle after reset release
    task automatic run_tv(input string tag);
        foreach (tv[i]) begin
            bus.ready_i_FC = tv[i].rdy;
            bus.redirect_i_FC = tv[i].rdr;
            bus.redirect_pc_i_FC = tv[i].rpc;
            @(negedge clk);
            chk($sformatf("%s c%0d ce", tag, i), bus.chip_enable_o_FC, tv[i].ce);
            if (tv[i].ce)
                chk($sformatf("%s c%0d addr", tag, i), bus.pc_addr_o_FC, tv[i].addr);
            chk($sformatf("%s c%0d valid", tag, i), bus.valid_o_FC, tv[i].vld);
            if (tv[i].vld) begin
                chk($sformatf("%s c%0d pc_o", tag, i), bus.pc_o_FC, tv[i].pc);
                chk($sformatf("%s c%0d instr_o", tag, i), bus.instr_o_FC,
                    rom_f(tv[i].pc));
            end
            chk($sformatf("%s c%0d misalign", tag, i), bus.misalign_o_FC, tv[i].mis);
            @(posedge clk);
            #1;
        end
        tv.delete();
    endtask

    logic [31:0] exp_fetch;
    logic [31:0] exp_deliv;
    logic [31:0] tgt;
    logic        rdy;
    logic        rdr;
    int          iss;
    int          dlv;
    int          streak;

    initial begin
        #1;
        do_reset(1'b1);

        // startup, steady stream, redirect with an in-flight read
        add(1, 0, 0,          0, 32'h0,   0, 0,          0);
        add(1, 0, 0,          1, 32'h0,   0, 0,          0);
        add(1, 0, 0,          1, 32'h4,   0, 0,          0);
        add(1, 0, 0,          1, 32'h8,   1, 32'h0,      0);
        add(1, 0, 0,          1, 32'hC,   1, 32'h4,      0);
        add(1, 0, 0,          1, 32'h10,  1, 32'h8,      0);
        add(1, 1, 32'h100,    0, 32'h0,   0, 0,          0);
        add(1, 0, 0,          1, 32'h100, 0, 0,          0);
        add(1, 0, 0,          1, 32'h104, 0, 0,          0);
        add(1, 0, 0,          1, 32'h108, 1, 32'h100,    0);
        add(1, 0, 0,          1, 32'h10C, 1, 32'h104,    0);
        run_tv("stream");

        do_reset(1'b1);

        // backpressure: two entries only, then pop credit
        add(0, 0, 0, 0, 32'h0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h4, 0, 0, 0);
        for (int k = 3; k < 13; k++)
            add(0, 0, 0, 0, 32'h0, 1, 32'h0, 0);
        add(1, 0, 0, 1, 32'h8,  1, 32'h0, 0);
        add(1, 0, 0, 1, 32'hC,  1, 32'h4, 0);
        add(1, 0, 0, 1, 32'h10, 1, 32'h8, 0);
        add(1, 0, 0, 1, 32'h14, 1, 32'hC, 0);
        run_tv("bp");

        do_reset(1'b0);

        // address wrap at the top of the space
        add(1, 0, 0,            0, 32'h0,         0, 0,            0);
        add(1, 0, 0,            1, 32'h0,         0, 0,            0);
        add(1, 0, 0,            1, 32'h4,         0, 0,            0);
        add(1, 1, 32'hFFFF_FFF8, 0, 32'h0,        0, 0,            0);
        add(1, 0, 0,            1, 32'hFFFF_FFF8, 0, 0,            0);
        add(1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,            0);
        add(1, 0, 0,            1, 32'h0,         1, 32'hFFFF_FFF8, 0);
        add(1, 0, 0,            1, 32'h4,         1, 32'hFFFF_FFFC, 0);
        add(1, 0, 0,            1, 32'h8,         1, 32'h0,         0);
        run_tv("wrap");

        do_reset(1'b0);

        add(1, 0, 0, 0, 32'h0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h4, 0, 0, 0);
`ifdef FC_MISALIGN_CHK_EN
        add(1, 1, 32'h102, 0, 32'h0,   0, 0,       0);
        add(1, 0, 0,       0, 32'h0,   0, 0,       1);
        add(1, 1, 32'h200, 0, 32'h0,   0, 0,       1);
        add(1, 0, 0,       1, 32'h200, 0, 0,       0);
        add(1, 0, 0,       1, 32'h204, 0, 0,       0);
        add(1, 0, 0,       1, 32'h208, 1, 32'h200, 0);
`else
        add(1, 1, 32'h102, 0, 32'h0,   0, 0,       0);
        add(1, 0, 0,       1, 32'h100, 0, 0,       0);
        add(1, 0, 0,       1, 32'h104, 0, 0,       0);
        add(1, 0, 0,       1, 32'h108, 1, 32'h100, 0);
        add(1, 0, 0,       1, 32'h10C, 1, 32'h104, 0);
`endif
        run_tv("misalign");

        // random run against the fetch-stream model
        do_reset(1'b0);
        exp_fetch = 32'h0;
        exp_deliv = 32'h0;
        iss = 0;
        dlv = 0;
        streak = -1;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(3) != 0);
            rdr = (c >= 2) && ($urandom_range(15) == 0);
            case ($urandom_range(3))
                0:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                default: tgt = $urandom & 32'h0000_FFFF;
            endcase
`ifdef FC_MISALIGN_CHK_EN
            tgt[1:0] = 2'b00;
`endif
            bus.ready_i_FC = rdy;
            bus.redirect_i_FC = rdr;
            bus.redirect_pc_i_FC = tgt;
            @(negedge clk);
            if (bus.chip_enable_o_FC) begin
                chk("rnd fetch addr", bus.pc_addr_o_FC, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                iss++;
            end
            if (rdr) begin
                chk("rnd strobe in redirect", bus.chip_enable_o_FC, 0);
                chk("rnd valid in redirect", bus.valid_o_FC, 0);
            end else if (bus.valid_o_FC && rdy) begin
                chk("rnd deliver pc", bus.pc_o_FC, exp_deliv);
                chk("rnd deliver instr", bus.instr_o_FC, rom_f(exp_deliv));
                exp_deliv = exp_deliv + 32'd4;
                dlv++;
            end
            chk("rnd occupancy over depth", 32'(iss - dlv > 2), 0);
            if (!rdr) begin
                if (bus.valid_o_FC) streak = 0;
                else streak++;
                chk("rnd valid gap", 32'(streak > 2), 0);
            end
            if (rdr) begin
                exp_fetch = tgt & ~32'd3;
                exp_deliv = tgt & ~32'd3;
                iss = 0;
                dlv = 0;
                streak = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC/instruction-ROM pair and the IF_ID stage of the rv32 core. It owns the fetch PC, drives the ROM address and chip enable, and tracks in-flight ROM reads. It buffers returned instructions in a small {pc, instr} queue and presents them to IF_ID over a valid/ready handshake. It also handles redirects from branch/jump resolution.

## Interface
- ADDR_W, 32, fetch address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, queue entries (power of two, ≥2)

Ports:
- clk_i_FC  in  1  core clock; all state updates on rising edge
- reset_i_FC  in  1  synchronous, active-low reset
- pc_addr_o_FC  out  ADDR_W  ROM read address
- chip_enable_o_FC  out  1  ROM read strobe; one read issued per high cycle
- instr_i_FC  in  INSTR_W  ROM data; valid exactly 1 cycle after the issuing strobe
- redirect_i_FC  in  1  taken branch/jump, one-cycle pulse
- redirect_pc_i_FC  in  ADDR_W  redirect target
- instr_o_FC  out  INSTR_W  head instruction to IF_ID
- pc_o_FC  out  ADDR_W  PC of head instruction
- valid_o_FC  out  1  head entry valid
- ready_i_FC  in  1  IF_ID accepts head
- misalign_o_FC  out  1  sticky fault flag (only with macro; tied 0 otherwise)

## Operation
- States: BOOT, RUN, FAULT (FAULT exists only with macro).
- Reset (reset_i_FC low at an edge):
  - state→BOOT, fetch_pc→RESET_PC, queue empty, in-flight cleared, misalign 0.
  - Outputs: chip_enable_o_FC 0, pc_addr_o_FC RESET_PC, valid_o_FC 0, instr_o_FC 0, pc_o_FC 0, misalign_o_FC 0.
- BOOT: strobe low for one cycle → RUN.
- RUN, issue rule:
  - Strobe high when count + inflight − pop < DEPTH and no redirect this cycle.
  - pc_addr_o_FC = fetch_pc; on issue, fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - inflight is one bit (the ROM holds one outstanding read).
- Response: in the cycle after an issue, {issued pc, instr_i_FC} is pushed to the queue tail unless a drop is pending.
- Handshake:
  - valid_o_FC = (count ≠ 0) && !redirect_i_FC.
  - Pop when valid_o_FC && ready_i_FC.
  - Head outputs hold stable while valid && !ready.
- Redirect (RUN):
  - Queue cleared at the cycle end.
  - Any read in flight is marked drop, and its data in the next cycle is discarded.
  - fetch_pc ← redirect_pc_i_FC; no issue in the redirect cycle.
- Simultaneous events:
  - Redirect + pop: no transfer occurs, because valid is forced low.
  - Push + pop: count is unchanged.
  - Push into a full queue cannot occur, by the issue rule.
- Reset mid-operation overrides everything; no in-flight data is written after reset.

## Timing
- Reset release at edge 0 gives BOOT in cycle 0. First strobe in cycle 1 (addr RESET_PC). Data pushed at end of cycle 2. valid_o_FC high in cycle 3.
- Steady state with ready held high: one instruction per cycle, no bubbles.
- Redirect in cycle N: first strobe at the target in N+1, valid_o_FC in N+3; redirect penalty 3 cycles.
- Backpressure: with ready low, at most DEPTH entries are accepted, then the strobe stays low. When ready returns, issue resumes in the same cycle (pop credit).

## Configuration
- Macro FC_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc_i_FC[1:0] ≠ 0 enters FAULT.
  - In FAULT: strobe low, queue cleared, misalign_o_FC high (sticky), valid low.
  - An aligned redirect in FAULT → RUN at that target and clears misalign_o_FC.
- Undefined:
  - No FAULT state; misalign_o_FC tied 0.
  - redirect_pc_i_FC[1:0] forced to 0 on load.

## Structure
- Shared define file holds: InstrAddrBus/InstrBus widths, RESET_PC default, state encodings (BOOT=2'd0, RUN=2'd1, FAULT=2'd2), PC increment constant 4.
- One sub-module, fc_fifo: parameterised {pc, instr} queue with push, pop, flush, count, and head outputs.

## Test plan
- Reset release, ready=1, ROM model returns addr-derived data → strobes at 0x0, 0x4, 0x8; valid in cycle 3 with pc_o 0x0; one instruction per cycle thereafter.
- ready held low 10 cycles → exactly 2 entries (pc 0x0, 0x4) queued, strobe low; ready high → pc 0x0, 0x4, 0x8 delivered in consecutive cycles, no duplicates or skips.
- Redirect to 0x100 in cycle 6, in-flight read at 0x10 → 0x10 data discarded; valid low in cycles 6–8; next pc_o 0x100.
- Redirect in the same cycle as valid&&ready → no transfer in that cycle; queue empty afterwards.
- fetch_pc at 0xFFFF_FFF8 → subsequent fetches at 0xFFFF_FFFC, then 0x0.
- With FC_MISALIGN_CHK_EN: redirect to 0x102 → misalign_o_FC 1, strobe low; redirect to 0x200 → RUN, misalign 0, pc_o 0x200. Without the macro: 0x102 fetched as 0x100.
